// File: rtl/coreabc_iram_loader_pkg.sv
// Shared types and constants for the CoreABC IRAM boot loader.
// Optional checksum support is selected with IRAM_LOADER_CHECKSUM_EN.
package coreabc_iram_loader_pkg;

  localparam int IRAM_DEPTH = 512;
  localparam int IRAM_DW    = 9;
  localparam int CSUM_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR,
    S_CSUM,
    S_FIN
  } state_t;

endpackage

// File: rtl/coreabc_iram_loader_fsm.sv
// Load sequencer: state register, next-state logic and datapath enables.
// IRAM_LOADER_CHECKSUM_EN inserts the CSUM state after the last word.
module coreabc_iram_loader_fsm
  import coreabc_iram_loader_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   abort,
  input  logic   svalid,
  input  logic   last,
  input  logic   csum_ok,
  output state_t state,
  output logic   sready,
  output logic   wenable,
  output logic   busy,
  output logic   done,
  output logic   xfer,
  output logic   start_acc,
  output logic   abort_acc
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Outputs are pure decodes of the registered state, so SREADY never
  // depends combinationally on SVALID and reset drops WENABLE at once.
  assign state     = state_q;
  assign sready    = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CSUM);
  assign wenable   = (state_q == S_WR);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN) && csum_ok;
  assign xfer      = sready && svalid;
  assign start_acc = (state_q == S_IDLE) && start;
  assign abort_acc = abort && (state_q == S_LO || state_q == S_HI ||
                               state_q == S_WR || state_q == S_CSUM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LO;
      S_LO: begin
        if (abort)     state_d = S_IDLE;
        else if (xfer) state_d = S_HI;
      end
      S_HI: begin
        if (abort)     state_d = S_IDLE;
        else if (xfer) state_d = S_WR;
      end
      S_WR: begin
        if (abort)     state_d = S_IDLE;
        else if (last) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_FIN;
`endif
        end
        else           state_d = S_LO;
      end
      S_CSUM: begin
        if (abort)     state_d = S_IDLE;
        else if (xfer) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/coreabc_iram_loader.sv
// CoreABC IRAM boot loader: byte stream -> 9-bit words on the IRAM init port.
// Define IRAM_LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module coreabc_iram_loader
  import coreabc_iram_loader_pkg::*;
#(
  parameter int DEPTH  = IRAM_DEPTH,
  parameter int AWIDTH = 9
) (
  input  logic               PCLK,
  input  logic               NSYSRESET,
  input  logic               START,
  input  logic [AWIDTH:0]    LENGTH,
  input  logic               ABORT,
  input  logic [7:0]         SDATA,
  input  logic               SVALID,
  output logic               SREADY,
  output logic [AWIDTH-1:0]  INITADDR,
  output logic [IRAM_DW-1:0] INITDATA,
  output logic               WENABLE,
  output logic               BUSY,
  output logic               CPU_HOLD,
  output logic               DONE,
  output logic               ERROR
);

  localparam int            LW      = AWIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t                state;
  logic                  xfer, start_acc, abort_acc, last, csum_ok, take;
  logic [LW-1:0]         len_q, len_d, len_clamp;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic [7:0]            low_q, low_d;
  logic [IRAM_DW-1:0]    data_q, data_d;
  logic                  err_q, err_d, hold_q, hold_d;

  coreabc_iram_loader_fsm u_fsm (
    .clk       (PCLK),
    .rst_n     (NSYSRESET),
    .start     (START),
    .abort     (ABORT),
    .svalid    (SVALID),
    .last      (last),
    .csum_ok   (csum_ok),
    .state     (state),
    .sready    (SREADY),
    .wenable   (WENABLE),
    .busy      (BUSY),
    .done      (DONE),
    .xfer      (xfer),
    .start_acc (start_acc),
    .abort_acc (abort_acc)
  );

  // Zero or oversize requests load the whole RAM, so the address never wraps.
  assign len_clamp = (LENGTH == '0 || LENGTH > DEPTH_L) ? DEPTH_L : LENGTH;
  assign last      = ({1'b0, addr_q} == (len_q - LW'(1)));
  assign take      = xfer && !ABORT;

`ifdef IRAM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (start_acc) acc_d = '0;
    else if (xfer) acc_d = acc_q + SDATA;
  end

  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) acc_q <= '0;
    else            acc_q <= acc_d;
  end

  assign csum_ok = (acc_q == '0);
`else
  logic unused_sdata;
  assign unused_sdata = ^SDATA[7:1];
  assign csum_ok      = 1'b1;
`endif

  always_comb begin
    len_d  = len_q;
    addr_d = addr_q;
    low_d  = low_q;
    data_d = data_q;
    err_d  = err_q;
    hold_d = hold_q;
    if (start_acc) begin
      len_d  = len_clamp;
      addr_d = '0;
      err_d  = 1'b0;
    end
    if (abort_acc) err_d = 1'b1;
    if (state == S_LO && take) low_d = SDATA;
    if (state == S_HI && take) data_d = {SDATA[0], low_q};
    if (state == S_WR && !ABORT && !last) addr_d = addr_q + AWIDTH'(1);
    if (state == S_FIN) begin
      if (csum_ok) hold_d = 1'b0;
      else         err_d  = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      len_q  <= '0;
      addr_q <= '0;
      low_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      len_q  <= len_d;
      addr_q <= addr_d;
      low_q  <= low_d;
      data_q <= data_d;
      err_q  <= err_d;
      hold_q <= hold_d;
    end
  end

  assign INITADDR = addr_q;
  assign INITDATA = data_q;
  assign ERROR    = err_q;
  assign CPU_HOLD = hold_q;

endmodule

// File: doc/coreabc_iram_loader.md
# coreabc_iram_loader

Boot-time image loader for the CoreABC 512x9 instruction RAM; it drives the RAM's initialisation write port (INITADDR/WENABLE/INITDATA). It accepts a byte stream with a valid/ready handshake, assembles pairs of bytes into 9-bit instructions, and writes them sequentially from address 0. It holds the CoreABC sequencer in reset until the image is complete. It sits between the boot source (SPI flash reader or UART bridge) and the IRAM, and shares the IRAM write clock.

## Interface
- DEPTH, 512, number of IRAM words; the address counter covers 0..DEPTH-1.
- AWIDTH, 9, width of INITADDR; must satisfy 2**AWIDTH >= DEPTH.
- PCLK  in  1  clock; must be the same clock as the IRAM RWCLK.
- NSYSRESET  in  1  asynchronous active-low reset.
- START  in  1  one-cycle load request; sampled only in IDLE.
- LENGTH  in  AWIDTH+1  words to load; sampled with START; 0 or >DEPTH means DEPTH.
- ABORT  in  1  synchronous abort; in any non-IDLE state it forces IDLE.
- SDATA  in  8  stream byte.
- SVALID  in  1  byte valid.
- SREADY  out  1  loader ready; a byte transfers when SVALID and SREADY are both high at the clock edge.
- INITADDR  out  AWIDTH  IRAM write address.
- INITDATA  out  9  IRAM write data.
- WENABLE  out  1  IRAM write strobe, one cycle per word.
- BUSY  out  1  load in progress.
- CPU_HOLD  out  1  holds CoreABC in reset; high from reset until the first successful DONE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERROR  out  1  sticky; cleared by the next accepted START.

## Operation
- States: IDLE, LO, HI, WR, CSUM, FIN.
- IDLE: SREADY=0. When START=1, latch LENGTH (clamped), clear the address counter, the checksum accumulator and ERROR, then go to LO.
- LO: SREADY=1. On transfer, store SDATA as the low byte and go to HI.
- HI: SREADY=1. On transfer, INITDATA = {SDATA[0], low byte}; SDATA[7:1] is ignored but still added to the checksum. Go to WR.
- WR: SREADY=0 and WENABLE=1 for exactly this cycle; INITADDR and INITDATA are stable throughout.
  - If this is the last word: go to CSUM (macro defined) or FIN (macro undefined).
  - Otherwise: increment the address and go to LO.
- CSUM: SREADY=1. On transfer, compare; go to FIN.
- FIN: pulse DONE and clear CPU_HOLD, unless ERROR was set. Then go to IDLE.
- ABORT in LO, HI, WR or CSUM:
  - Return to IDLE and set ERROR; DONE is not pulsed and CPU_HOLD is unchanged.
  - The IRAM keeps any words already written.
  - If ABORT is asserted in WR, the write in that cycle still occurs.
- START outside IDLE is ignored.
- Address wrap: the address never exceeds DEPTH-1, because the word count is clamped.
- Reset values: SREADY, WENABLE, BUSY, DONE and ERROR are 0; CPU_HOLD is 1; INITADDR and INITDATA are 0; state is IDLE.
- Reset asserted mid-load aborts immediately. WENABLE drops asynchronously; the partial image is left in the IRAM.

## Timing
- Each word takes at least 3 cycles (LO, HI, WR). A full 512-word image takes at least 1536 cycles + 1 (FIN), + 1 with checksum.
- WENABLE is high in the cycle after the HI byte transfer; the IRAM captures the word on the rising edge that ends WR.
- BUSY is high from the cycle after START through the FIN cycle inclusive.
- DONE is high during FIN. CPU_HOLD falls on the edge that ends FIN.
- SREADY is a registered state decode. It does not depend combinationally on SVALID.

## Configuration
- IRAM_LOADER_CHECKSUM_EN defined:
  - After the last word, one extra stream byte is required.
  - An 8-bit accumulator sums every byte of the image mod 256.
  - The sum of all image bytes plus the checksum byte must equal 0x00; otherwise ERROR is set in FIN and DONE is suppressed.
- IRAM_LOADER_CHECKSUM_EN undefined:
  - The CSUM state and the accumulator are absent.
  - WR goes directly to FIN; ERROR is set only by ABORT.

## Structure
- The shared package holds:
  - the state enumeration;
  - the IRAM depth and data-width constants (512, 9);
  - the checksum width (8).
- One sub-module: coreabc_iram_loader_fsm (state register, next-state logic, counter control). The datapath (byte latch, address counter, accumulator) stays in the top level.

## Test plan
- LENGTH=4, bytes 0x12,0x01, 0x34,0x00, 0xFF,0x01, 0x00,0x00, SVALID held high:
  - WENABLE pulses at addresses 0..3 with data 0x112, 0x034, 0x1FF, 0x000.
  - DONE pulses in cycle 13; CPU_HOLD=0 afterwards.
- LENGTH=0:
  - Exactly 512 writes, the last to INITADDR=0x1FF; no write beyond it.
- SVALID toggled randomly:
  - No write occurs until both bytes of a word are transferred.
  - Data matches the byte pairs; SREADY is never high in WR.
- ABORT asserted in HI of word 2:
  - ERROR=1, no DONE, CPU_HOLD stays 1, only words 0..1 are written.
  - A following START clears ERROR.
- NSYSRESET pulsed low mid-load:
  - All outputs return to reset values within the same cycle; CPU_HOLD=1.
- With IRAM_LOADER_CHECKSUM_EN, LENGTH=1, bytes 0x10,0x01:
  - Checksum byte 0xEF: DONE pulses.
  - Checksum byte 0xEE: ERROR=1 and no DONE.
